// File: rtl/cordic_sincos_scheduler.sv
// Shares one in-order CORDIC sin/cos core between NREQ requesters.
// A round-robin arbiter issues one angle per cycle through a registered
// issue stage. The requester ID goes into a tag FIFO. Each returning core
// result pops one tag, and the result is steered back to that requester
// with a one-hot response valid.
module cordic_sincos_scheduler #(
  parameter int NREQ         = 4,
  parameter int REQ_W        = 2,
  parameter int MAX_INFLIGHT = 16,
  parameter int CNT_W        = 5
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic [NREQ-1:0]     iReq_valid,
  input  logic [NREQ*32-1:0]  iReq_angle,
  output logic [NREQ-1:0]     oReq_ready,
  output logic                oCore_valid,
  output logic [31:0]         oCore_angle,
  input  logic                iCore_valid,
  input  logic [31:0]         iCore_sin,
  input  logic [31:0]         iCore_cos,
  output logic [NREQ-1:0]     oResp_valid,
  output logic [31:0]         oResp_sin,
  output logic [31:0]         oResp_cos,
  output logic [CNT_W-1:0]    oInflight,
  output logic                oErr_underflow
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);

  logic [REQ_W-1:0] r_last_grant;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [REQ_W-1:0] r_tag_mem [MAX_INFLIGHT];
  logic [CNT_W-1:0] r_inflight;
  logic             r_err;

  logic             r_core_vld_p1;
  logic [31:0]      r_core_angle_p1;
  logic [NREQ-1:0]  r_resp_vld_p1;
  logic [31:0]      r_resp_sin_p1;
  logic [31:0]      r_resp_cos_p1;

  logic             w_found;
  logic [REQ_W-1:0] w_grant_id;
  logic             w_can_issue;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_angle;

  // Count is compared before any same-cycle return, so a full core stays full for that cycle
  assign w_can_issue = (r_inflight < CNT_W'(MAX_INFLIGHT));
  assign w_push      = w_found && w_can_issue;
  // Empty FIFO equals zero in-flight count; a result then is an underflow, not a pop
  assign w_pop       = iCore_valid && (r_inflight != '0);
  assign w_angle     = iReq_angle[int'(w_grant_id)*32 +: 32];

  // Round-robin search starting just after the last granted requester
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    oReq_ready = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && iReq_valid[REQ_W'((int'(r_last_grant) + k) % NREQ)]) begin
        w_found    = 1'b1;
        w_grant_id = REQ_W'((int'(r_last_grant) + k) % NREQ);
      end
    end
    if (w_found && w_can_issue) begin
      oReq_ready = NREQ'(1) << w_grant_id;
    end
  end

  // Control state: arbiter pointer, FIFO pointers, in-flight count, error flag
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_last_grant <= REQ_W'(NREQ - 1);
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_inflight   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_push) begin
        r_last_grant <= w_grant_id;
        r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (iCore_valid && (r_inflight == '0)) begin
        r_err <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Tag storage holds the requester ID of each outstanding operation
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_grant_id;
    end
  end

  // Stage p1: issue register toward the core and response register toward requesters
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_core_vld_p1   <= 1'b0;
      r_core_angle_p1 <= '0;
      r_resp_vld_p1   <= '0;
      r_resp_sin_p1   <= '0;
      r_resp_cos_p1   <= '0;
    end else begin
      r_core_vld_p1 <= w_push;
      if (w_push) begin
        r_core_angle_p1 <= w_angle;
      end
      r_resp_vld_p1 <= w_pop ? (NREQ'(1) << r_tag_mem[r_rd_ptr]) : '0;
      if (w_pop) begin
        r_resp_sin_p1 <= iCore_sin;
        r_resp_cos_p1 <= iCore_cos;
      end
    end
  end

  assign oCore_valid    = r_core_vld_p1;
  assign oCore_angle    = r_core_angle_p1;
  assign oResp_valid    = r_resp_vld_p1;
  assign oResp_sin      = r_resp_sin_p1;
  assign oResp_cos      = r_resp_cos_p1;
  assign oInflight      = r_inflight;
  assign oErr_underflow = r_err;

endmodule

// File: tb/tb_cordic_sincos_scheduler.sv
// Testbench for cordic_sincos_scheduler: directed vector table, hand
// sequences for the full, wrap, underflow and reset cases, and random
// traffic checked against a queue-based reference model.
module tb_cordic_sincos_scheduler;

  logic         iClk;
  logic         iReset_n;
  logic [3:0]   iReq_valid;
  logic [127:0] iReq_angle;
  logic [3:0]   oReq_ready;
  logic         oCore_valid;
  logic [31:0]  oCore_angle;
  logic         iCore_valid;
  logic [31:0]  iCore_sin;
  logic [31:0]  iCore_cos;
  logic [3:0]   oResp_valid;
  logic [31:0]  oResp_sin;
  logic [31:0]  oResp_cos;
  logic [4:0]   oInflight;
  logic         oErr_underflow;

  cordic_sincos_scheduler #(
    .NREQ(4), .REQ_W(2), .MAX_INFLIGHT(16), .CNT_W(5)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n),
    .iReq_valid(iReq_valid), .iReq_angle(iReq_angle), .oReq_ready(oReq_ready),
    .oCore_valid(oCore_valid), .oCore_angle(oCore_angle),
    .iCore_valid(iCore_valid), .iCore_sin(iCore_sin), .iCore_cos(iCore_cos),
    .oResp_valid(oResp_valid), .oResp_sin(oResp_sin), .oResp_cos(oResp_cos),
    .oInflight(oInflight), .oErr_underflow(oErr_underflow)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] ang [4];

  // Reference model state
  int          m_q[$];
  int          m_last;
  logic        m_err;
  logic        m_core_vld;
  logic [31:0] m_angle;
  logic [3:0]  m_resp;
  logic [31:0] m_sin;
  logic [31:0] m_cos;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic        cv;
    logic [3:0]  rdy;
    logic        cvld;
    logic [31:0] angle;
    logic [3:0]  resp;
    int          infl;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_angles();
    iReq_angle = {ang[3], ang[2], ang[1], ang[0]};
  endtask

  task automatic add(input bit rst, input logic [3:0] req, input logic cv,
                     input logic [3:0] rdy, input logic cvld, input logic [31:0] a,
                     input logic [3:0] resp, input int infl);
    vec_t v;
    v.rst = rst; v.req = req; v.cv = cv; v.rdy = rdy; v.cvld = cvld;
    v.angle = a; v.resp = resp; v.infl = infl;
    tbl.push_back(v);
  endtask

  task automatic check_model();
    chk("core_valid", {31'd0, oCore_valid}, {31'd0, m_core_vld});
    chk("core_angle", oCore_angle, m_angle);
    chk("resp_valid", {28'd0, oResp_valid}, {28'd0, m_resp});
    chk("resp_sin", oResp_sin, m_sin);
    chk("resp_cos", oResp_cos, m_cos);
    chk("inflight", {27'd0, oInflight}, m_q.size());
    chk("err_underflow", {31'd0, oErr_underflow}, {31'd0, m_err});
  endtask

  task automatic do_reset();
    iReset_n = 1'b0; iReq_valid = '0; iCore_valid = 1'b0;
    @(posedge iClk); #1;
    iReset_n = 1'b1;
    m_q.delete(); m_last = 3; m_err = 1'b0; m_core_vld = 1'b0;
    m_angle = '0; m_resp = '0; m_sin = '0; m_cos = '0;
    check_model();
    chk("reset_ready", {28'd0, oReq_ready}, 32'd0);
  endtask

  // One cycle: drive inputs, check the grant, advance model, check registered outputs
  task automatic cyc(input logic [3:0] req, input logic cv);
    int g;
    logic [3:0] exp_rdy;
    iReq_valid = req; iCore_valid = cv;
    iCore_sin = $urandom; iCore_cos = $urandom;
    #1;
    g = -1;
    if (m_q.size() < 16) begin
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && req[(m_last + k) % 4]) g = (m_last + k) % 4;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", {28'd0, oReq_ready}, {28'd0, exp_rdy});
    m_resp = '0;
    if (cv) begin
      if (m_q.size() == 0) begin
        m_err = 1'b1;
      end else begin
        m_resp = 4'(1 << m_q.pop_front());
        m_sin = iCore_sin; m_cos = iCore_cos;
      end
    end
    m_core_vld = (g >= 0);
    if (g >= 0) begin
      m_q.push_back(g); m_last = g; m_angle = ang[g];
    end
    @(posedge iClk); #1;
    check_model();
  endtask

  initial begin
    iReset_n = 1'b0; iReq_valid = '0; iCore_valid = 1'b0;
    iCore_sin = '0; iCore_cos = '0;
    ang[0] = 32'h3F490FDB; ang[1] = 32'h11111111;
    ang[2] = 32'h22222222; ang[3] = 32'h33333333;
    set_angles();

    // Directed vectors: single request, then round-robin issue and in-order return
    add(1, 4'b0000, 0, 4'b0000, 0, 32'h0, 4'b0000, 0);
    add(0, 4'b0001, 0, 4'b0001, 1, ang[0], 4'b0000, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, ang[0], 4'b0001, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 32'h0, 4'b0000, 0);
    for (int i = 0; i < 8; i++)
      add(0, 4'b1111, 0, 4'(1 << (i % 4)), 1, ang[i % 4], 4'b0000, i + 1);
    for (int i = 0; i < 8; i++)
      add(0, 4'b0000, 1, 4'b0000, 0, ang[3], 4'(1 << (i % 4)), 7 - i);

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        iReq_valid = tbl[i].req; iCore_valid = tbl[i].cv;
        iCore_sin = 32'h3F3504F3; iCore_cos = 32'h3F3504F3;
        #1;
        chk("tbl_ready", {28'd0, oReq_ready}, {28'd0, tbl[i].rdy});
        @(posedge iClk); #1;
        chk("tbl_core_valid", {31'd0, oCore_valid}, {31'd0, tbl[i].cvld});
        chk("tbl_core_angle", oCore_angle, tbl[i].angle);
        chk("tbl_resp_valid", {28'd0, oResp_valid}, {28'd0, tbl[i].resp});
        chk("tbl_inflight", {27'd0, oInflight}, tbl[i].infl);
        if (tbl[i].resp != 0) begin
          chk("tbl_resp_sin", oResp_sin, 32'h3F3504F3);
          chk("tbl_resp_cos", oResp_cos, 32'h3F3504F3);
        end
      end
    end

    // Full: 16 issues, blocked while full even with a same-cycle return
    do_reset();
    for (int i = 0; i < 16; i++) cyc(4'b0001, 1'b0);
    chk("full_inflight", {27'd0, oInflight}, 32'd16);
    cyc(4'b0001, 1'b0);
    chk("full_no_issue", {31'd0, oCore_valid}, 32'd0);
    cyc(4'b0001, 1'b1);
    chk("full_ret_inflight", {27'd0, oInflight}, 32'd15);
    chk("full_ret_no_issue", {31'd0, oCore_valid}, 32'd0);
    cyc(4'b0001, 1'b0);
    chk("full_reissue", {31'd0, oCore_valid}, 32'd1);
    for (int i = 0; i < 16; i++) cyc(4'b0000, 1'b1);
    chk("full_drained", {27'd0, oInflight}, 32'd0);

    // Simultaneous issue and return at 5 outstanding, running past the FIFO wrap
    do_reset();
    for (int i = 0; i < 5; i++) cyc(4'b1111, 1'b0);
    for (int i = 0; i < 24; i++) begin
      cyc(4'b1111, 1'b1);
      chk("simul_inflight", {27'd0, oInflight}, 32'd5);
    end
    for (int i = 0; i < 5; i++) cyc(4'b0000, 1'b1);

    // Underflow after reset with nothing issued
    do_reset();
    cyc(4'b0000, 1'b1);
    chk("uflow_flag", {31'd0, oErr_underflow}, 32'd1);
    chk("uflow_resp", {28'd0, oResp_valid}, 32'd0);
    chk("uflow_inflight", {27'd0, oInflight}, 32'd0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("uflow_sticky", {31'd0, oErr_underflow}, 32'd1);

    // Reset with 7 outstanding: outputs clear and priority returns to requester 0
    do_reset();
    for (int i = 0; i < 7; i++) cyc(4'b0110, 1'b0);
    chk("mid_inflight", {27'd0, oInflight}, 32'd7);
    do_reset();
    iReq_valid = 4'b1111;
    #1;
    chk("mid_prio0", {28'd0, oReq_ready}, 32'd1);
    cyc(4'b1111, 1'b0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4; i++) ang[i] = $urandom;
    set_angles();
    for (int i = 0; i < 400; i++) begin
      cyc(4'($urandom_range(0, 15)),
          (m_q.size() > 0) && ($urandom_range(0, 2) != 0));
    end
    while (m_q.size() > 0) cyc(4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_sincos_scheduler.md
Name: cordic_sincos_scheduler

Overview:
- Shares one in-order CORDIC sin/cos pipeline, including its recovery stage, between NREQ angle requesters.
- Round-robin arbitration picks one requester per cycle and issues its angle to the core with a registered issue stage.
- The requester ID is held in an in-flight tag FIFO and is popped when the result returns.
- The returned sin/cos pair is steered back to the originating requester with a one-hot valid.

Parameters:
- NREQ, 4, number of requesters (2..8)
- REQ_W, 2, requester ID width (clog2 of NREQ)
- MAX_INFLIGHT, 16, maximum outstanding core operations; equals tag FIFO depth (power of 2)
- CNT_W, 5, in-flight counter width (clog2(MAX_INFLIGHT)+1)

Ports:
- iClk  in  1  clock; all logic on the rising edge
- iReset_n  in  1  synchronous reset, active-low
- iReq_valid  in  NREQ  per-requester request valid
- iReq_angle  in  NREQ*32  flattened angles; requester i uses bits [32i+31:32i]
- oReq_ready  out  NREQ  one-hot grant; a transfer occurs when iReq_valid[i] & oReq_ready[i]
- oCore_valid  out  1  issue strobe to the CORDIC core
- oCore_angle  out  32  angle issued to the core
- iCore_valid  in  1  result valid from the core's recovery stage
- iCore_sin  in  32  result sine
- iCore_cos  in  32  result cosine
- oResp_valid  out  NREQ  one-hot response valid
- oResp_sin  out  32  response sine
- oResp_cos  out  32  response cosine
- oInflight  out  CNT_W  current outstanding count
- oErr_underflow  out  1  sticky flag: core result arrived with the tag FIFO empty

Behaviour:
- Reset (iReset_n=0 at an edge) clears the following:
  - oCore_valid, oCore_angle, oResp_valid, oResp_sin, oResp_cos, oInflight, oErr_underflow all go to 0.
  - Tag FIFO read and write pointers go to 0.
  - Round-robin pointer last_grant goes to NREQ-1, so requester 0 has first priority.
- Reset mid-operation discards all in-flight tags. Core results arriving after reset with the FIFO empty set oErr_underflow; the system must reset the core together with this block.
- Arbitration is combinational from iReq_valid, last_grant and can_issue.
  - can_issue = (oInflight < MAX_INFLIGHT).
  - The grant goes to the first valid requester searching last_grant+1, +2, … modulo NREQ.
  - oReq_ready is all-zero when can_issue=0 or no request is valid.
  - At most one bit of oReq_ready is set.
- Issue (1-cycle latency):
  - On a transfer for requester g: the next cycle has oCore_valid=1 and oCore_angle = angle of g.
  - g is written to the tag FIFO at the transfer edge, and last_grant is set to g.
  - Without a transfer, oCore_valid=0 and oCore_angle holds its previous value.
- A requester must hold iReq_valid and its angle stable until granted. Dropping valid before the grant is legal and simply withdraws the request.
- The core is in-order: each iCore_valid pops exactly one tag.
- Response (1-cycle latency): iCore_valid=1 with FIFO non-empty gives, next cycle:
  - oResp_valid = one-hot of the popped tag.
  - oResp_sin = iCore_sin, oResp_cos = iCore_cos.
- Otherwise oResp_valid=0 and the sin/cos outputs hold. Requesters cannot back-pressure responses.
- Underflow: iCore_valid=1 with the FIFO empty sets oErr_underflow (sticky until reset). No pop occurs, oResp_valid stays 0, and oInflight stays at 0 (no wrap).
- Counter rules:
  - Issue only: oInflight +1.
  - Return only: oInflight -1.
  - Issue and return in the same cycle: oInflight unchanged; FIFO push and pop both occur.
- Full condition: can_issue uses the registered count. A return in the same cycle does not enable an issue while oInflight == MAX_INFLIGHT.
- FIFO pointers are REQ_W-wide storage indexed by log2(MAX_INFLIGHT)-bit pointers that wrap modulo MAX_INFLIGHT.

Test Plan:
- Single request: iReq_valid=0001, angle0=32'h3F490FDB. Required: oReq_ready=0001 the same cycle; oCore_valid=1 with that angle next cycle. Then drive core sin=32'h3F3504F3, cos=32'h3F3504F3. Required: oResp_valid=0001 with those values one cycle after iCore_valid; oInflight goes 0→1→0.
- Round-robin: all four requesters held valid for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3. Returns in order produce oResp_valid 0001,0010,0100,1000,…
- Full: core returns withheld, request 0 held valid. Required: 16 issues, then oInflight=16 and oReq_ready=0. With iCore_valid high at the same time as oInflight==16, there is no issue that cycle and oInflight=15. The next cycle issues.
- Simultaneous issue and return at oInflight=5. Required: oInflight stays 5 and tag order is preserved across FIFO wrap after more than 16 total operations.
- Underflow: iCore_valid=1 after reset with nothing issued. Required: oErr_underflow=1 persisting, oResp_valid=0, oInflight=0.
- Reset mid-operation with oInflight=7. Required: all outputs 0 the next cycle and grant priority returns to requester 0.
